cfg_commit_ctrl: RTL and testbench
==================================

Name: cfg_commit_ctrl

Overview:
- Double-buffered configuration bank. It sits between the SPI slave write port and the sync, ign_driver and inj_driver consumers in efi_main.
- SPI writes land in a shadow bank. The whole bank is copied atomically to the active bank only at a safe engine point: the trigger pulse, or any time while not synced.
- Purpose: no driver ever sees a half-updated config mid-cycle.

Parameters:
- TIMEOUT_CYCLES, 24'd2_000_000: max clk cycles a pending commit waits for a trigger (used only with CFG_COMMIT_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  shadow write strobe, already in the clk domain.
- wr_addr  in  4  shadow register index.
- wr_data  in  16  shadow write data.
- rd_addr  in  4  readback index.
- rd_shadow  in  1  1 = read the shadow bank, 0 = read the active bank.
- rd_data  out  16  registered readback.
- commit_req  in  1  single-cycle request to commit shadow to active.
- trigger  in  1  engine trigger pulse from sync.
- synced  in  1  sync status.
- cfg_bus  out  256  active bank flattened; reg i at [16i+15:16i].
- busy  out  1  commit pending or in progress.
- dirty  out  1  shadow holds writes not yet committed.
- commit_done  out  1  one-cycle pulse when the active bank updates.
- timed_out  out  1  sticky: a commit was forced by timeout.

Behaviour:
- Reset, taken while reset_n==0 at posedge clk:
  - Shadow and active banks both load these defaults: r0=0x0037, r1=60, r2=128, r3=2, r4=0, r5=7680, r6=0, r7=2560, r8=5120, r9=0, r10=342, r11=342, r12=2000, r13=0, r14=0, r15=0.
  - state=IDLE; rd_data=0, busy=0, dirty=0, commit_done=0, timed_out=0; timeout counter=0.
  - Reset mid-commit abandons the pending commit; the active bank returns to defaults.
- Shadow write: when wr_en=1, sh[wr_addr] takes wr_data at the next edge. Writes are accepted in every state. dirty is set the same edge.
- Readback: rd_data <= rd_shadow ? sh[rd_addr] : act[rd_addr]. Latency is 1 cycle and reflects bank contents before any same-edge write or commit.
- FSM, 2-bit, states IDLE / ARMED / COMMIT:
  - IDLE: commit_req and !synced -> COMMIT. commit_req and synced -> ARMED, counter cleared.
  - ARMED: trigger=1 -> COMMIT. synced=0 -> COMMIT. Otherwise stay, counter increments. commit_req while ARMED is ignored (already pending).
  - COMMIT, exactly one cycle:
    - At this edge act[0..15] <= sh[0..15] and commit_done=1 for that cycle (visible together with the new cfg_bus).
    - dirty clears unless wr_en=1 in the same cycle. That write reaches only the shadow, which is the pre-write copy; dirty stays 1.
    - Next state: if commit_req=1 in this cycle -> COMMIT when !synced, else ARMED. Otherwise -> IDLE.
- A trigger coinciding with commit_req in IDLE while synced does not commit. The commit waits for the next trigger, because the request is not armed until the edge.
- busy = (state != IDLE), registered with the state.
- cfg_bus changes only on the COMMIT edge or reset. No combinational path from wr_* to cfg_bus.
- Counter is 24 bits, saturating; it never wraps.

Optional Feature:
- Macro: CFG_COMMIT_TIMEOUT_EN.
- Defined: in ARMED, when counter == TIMEOUT_CYCLES-1 and no trigger and synced, next state is COMMIT and timed_out sets (sticky until reset). If trigger arrives on the same cycle, it is a normal commit and timed_out is unchanged.
- Undefined: no counter logic; ARMED waits indefinitely for trigger or loss of sync; timed_out is tied 0.

Test Plan:
- Reset -> cfg_bus[15:0]=0x0037, cfg_bus[175:160]=342, cfg_bus[207:192]=2000; busy=0, dirty=0.
- synced=0: write r10=400, pulse commit_req -> dirty=1; COMMIT next cycle; r10 field = 400 one cycle after that with commit_done pulse; dirty=0.
- synced=1: write r12=3000, commit_req, no trigger for 50 cycles -> r12 field stays 2000, busy=1. Trigger -> the following edge r12=3000, commit_done=1, busy falls the next cycle.
- ARMED, write r11=500 on the exact COMMIT cycle -> r11 field keeps its pre-write value, shadow r11=500, dirty=1. Read with rd_shadow=1, rd_addr=11 -> 500 after 1 cycle.
- ARMED, synced drops to 0 with no trigger -> commit occurs; commit_req in the COMMIT cycle with synced=1 -> returns to ARMED.
- CFG_COMMIT_TIMEOUT_EN, TIMEOUT_CYCLES=16, synced=1, no trigger -> commit after 16 ARMED cycles, timed_out=1 and stays 1. Repeat without the macro -> no commit after 1000 cycles.

Source files
------------

// File: rtl/cfg_commit_ctrl_if.sv
// Port bundle for cfg_commit_ctrl: shadow write/readback, commit request/status, active bank.
// commit_req and commit_done are single-cycle pulses; the controller always accepts a request (no ready),
// and a request made while one is already pending is absorbed by the pending commit.
interface cfg_commit_ctrl_if;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic [3:0]   rd_addr;
  logic         rd_shadow;
  logic [15:0]  rd_data;
  logic         commit_req;
  logic         trigger;
  logic         synced;
  logic [255:0] cfg_bus;
  logic         busy;
  logic         dirty;
  logic         commit_done;
  logic         timed_out;
  logic [1:0]   dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rd_shadow, commit_req, trigger, synced,
    input  rd_data, cfg_bus, busy, dirty, commit_done, timed_out, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rd_shadow, commit_req, trigger, synced,
    output rd_data, cfg_bus, busy, dirty, commit_done, timed_out, dbg_state
  );
endinterface

// File: rtl/cfg_commit_ctrl.sv
// Double-buffered config bank: shadow takes SPI writes, active copies the whole shadow at a safe engine point.
// Optional macro CFG_COMMIT_TIMEOUT_EN forces a pending commit after TIMEOUT_CYCLES without a trigger.
module cfg_commit_ctrl #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
  input  logic          clk,
  input  logic          reset_n,
  cfg_commit_ctrl_if.slave cfg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [15:0] DEFAULTS [16] = '{
    16'h0037, 16'd60,   16'd128,  16'd2,
    16'd0,    16'd7680, 16'd0,    16'd2560,
    16'd5120, 16'd0,    16'd342,  16'd342,
    16'd2000, 16'd0,    16'd0,    16'd0
  };

  // A zero timeout would make the terminal count underflow.
  if (TIMEOUT_CYCLES == 24'd0) begin : g_bad_timeout
    $error("cfg_commit_ctrl: TIMEOUT_CYCLES must be nonzero");
  end

  logic [15:0] sh  [16];
  logic [15:0] act [16];
  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        arm;
  logic        timeout_fire;
  logic        timed_out_q;
  logic [15:0] rd_data_q;
  logic        busy_q;
  logic        dirty_q;
  logic        commit_done_q;

`ifdef CFG_COMMIT_TIMEOUT_EN
  logic [23:0] wait_cnt;
`endif

  // Next-state: arm clears the wait counter whenever ARMED is entered.
  always_comb begin
    state_next   = state;
    arm          = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      IDLE: begin
        if (cfg.commit_req) begin
          state_next = cfg.synced ? ARMED : COMMIT;
          arm        = cfg.synced;
        end
      end
      ARMED: begin
        if (cfg.trigger || !cfg.synced) begin
          state_next = COMMIT;
        end
`ifdef CFG_COMMIT_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_CYCLES - 24'd1) begin
          state_next   = COMMIT;
          timeout_fire = 1'b1;
        end
`endif
      end
      COMMIT: begin
        if (cfg.commit_req) begin
          state_next = cfg.synced ? ARMED : COMMIT;
          arm        = cfg.synced;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      busy_q        <= 1'b0;
      dirty_q       <= 1'b0;
      commit_done_q <= 1'b0;
      rd_data_q     <= 16'd0;
    end else begin
      state         <= state_next;
      busy_q        <= (state_next != IDLE);
      commit_done_q <= (state == COMMIT);
      rd_data_q     <= cfg.rd_shadow ? sh[cfg.rd_addr] : act[cfg.rd_addr];
      // A write landing on the commit edge misses the copy, so the shadow stays dirty.
      if (cfg.wr_en) begin
        dirty_q <= 1'b1;
      end else if (state == COMMIT) begin
        dirty_q <= 1'b0;
      end
    end
  end

  // Bank storage: active copies the pre-write shadow on the COMMIT edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        sh[i]  <= DEFAULTS[i];
        act[i] <= DEFAULTS[i];
      end
    end else begin
      if (state == COMMIT) begin
        for (int i = 0; i < 16; i++) begin
          act[i] <= sh[i];
        end
      end
      if (cfg.wr_en) begin
        sh[cfg.wr_addr] <= cfg.wr_data;
      end
    end
  end

`ifdef CFG_COMMIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt    <= 24'd0;
      timed_out_q <= 1'b0;
    end else begin
      if (arm) begin
        wait_cnt <= 24'd0;
      end else if (state == ARMED && wait_cnt != 24'hFF_FFFF) begin
        wait_cnt <= wait_cnt + 24'd1;
      end
      if (timeout_fire) begin
        timed_out_q <= 1'b1;
      end
    end
  end
`else
  assign timed_out_q = 1'b0;
`endif

  always_comb begin
    cfg.cfg_bus = '0;
    for (int i = 0; i < 16; i++) begin
      cfg.cfg_bus[16*i +: 16] = act[i];
    end
  end

  assign cfg.rd_data     = rd_data_q;
  assign cfg.busy        = busy_q;
  assign cfg.dirty       = dirty_q;
  assign cfg.commit_done = commit_done_q;
  assign cfg.timed_out   = timed_out_q;
  assign cfg.dbg_state   = state;

endmodule

// File: tb/tb_cfg_commit_ctrl.sv
// Scoreboard bench for cfg_commit_ctrl: a bank-level reference model predicts every cycle's outputs
// and every commit snapshot; a monitor compares them against the DUT after each edge.
module tb_cfg_commit_ctrl;
  localparam logic [23:0] TMO = 24'd16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cfg_commit_ctrl_if bus ();

  cfg_commit_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cfg     (bus.slave)
  );

  // Reference model state: banks plus "a commit is waiting" / "copy happens at the next edge".
  logic [15:0] m_sh  [16];
  logic [15:0] m_act [16];
  logic [15:0] defaults [16] = '{
    16'h0037, 16'd60, 16'd128, 16'd2, 16'd0, 16'd7680, 16'd0, 16'd2560,
    16'd5120, 16'd0, 16'd342, 16'd342, 16'd2000, 16'd0, 16'd0, 16'd0
  };
  bit m_pending, m_copy_next, m_dirty, m_timed_out;
  int m_waited;

  // {cfg_bus, rd_data, busy, dirty, commit_done, timed_out}
  logic [275:0] exp_q[$];
  logic [255:0] exp_commit_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [255:0] flat_act();
    logic [255:0] f;
    for (int i = 0; i < 16; i++) f[16*i +: 16] = m_act[i];
    return f;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic request_commit(input bit syn);
    if (syn) begin
      m_pending = 1'b1;
      m_waited  = 0;
    end else begin
      m_copy_next = 1'b1;
    end
  endtask

  task automatic step(input bit rst_n, input bit we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic [3:0] ra, input bit rs, input bit req, input bit trig, input bit syn);
    logic [15:0] rd_exp;
    bit done;
    @(negedge clk);
    reset_n        = rst_n;
    bus.wr_en      = we;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.rd_addr    = ra;
    bus.rd_shadow  = rs;
    bus.commit_req = req;
    bus.trigger    = trig;
    bus.synced     = syn;
    done = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_sh[i]  = defaults[i];
        m_act[i] = defaults[i];
      end
      m_pending = 0; m_copy_next = 0; m_dirty = 0; m_timed_out = 0; m_waited = 0;
      rd_exp = 16'd0;
    end else begin
      rd_exp = rs ? m_sh[ra] : m_act[ra];
      if (m_copy_next) begin
        for (int i = 0; i < 16; i++) m_act[i] = m_sh[i];
        done = 1'b1;
        m_copy_next = 1'b0;
        m_dirty = 1'b0;
        if (req) request_commit(syn);
      end else if (m_pending) begin
        if (trig || !syn) begin
          m_pending = 1'b0;
          m_copy_next = 1'b1;
        end
`ifdef CFG_COMMIT_TIMEOUT_EN
        else if (m_waited == int'(TMO) - 1) begin
          m_pending = 1'b0;
          m_copy_next = 1'b1;
          m_timed_out = 1'b1;
        end
`endif
        else begin
          m_waited++;
        end
      end else if (req) begin
        request_commit(syn);
      end
      if (we) begin
        m_sh[wa] = wd;
        m_dirty = 1'b1;
      end
    end
    if (done) exp_commit_q.push_back(flat_act());
    exp_q.push_back({flat_act(), rd_exp, (m_pending || m_copy_next), m_dirty, done, m_timed_out});
  endtask

  task automatic idle(input int n, input bit syn);
    for (int i = 0; i < n; i++)
      step(1, 0, 4'd0, 16'd0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0, 0, syn);
  endtask

  // Monitor: pops one expectation per edge and one snapshot per commit_done pulse.
  always @(posedge clk) begin
    logic [275:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cfg_bus",     bus.cfg_bus,     e[275:20]);
      chk("rd_data",     bus.rd_data,     e[19:4]);
      chk("busy",        bus.busy,        e[3]);
      chk("dirty",       bus.dirty,       e[2]);
      chk("commit_done", bus.commit_done, e[1]);
      chk("timed_out",   bus.timed_out,   e[0]);
    end
    if (bus.commit_done === 1'b1) begin
      if (exp_commit_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL commit_unexpected got=commit_done want=no_commit at %0t", $time);
      end else begin
        chk("commit_snapshot", bus.cfg_bus, exp_commit_q.pop_front());
      end
    end
  end

  initial begin
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.rd_addr = 0;
    bus.rd_shadow = 0; bus.commit_req = 0; bus.trigger = 0; bus.synced = 0;

    repeat (3) step(0, 0, 4'd0, 16'd0, 4'd0, 0, 0, 0, 0);
    idle(2, 0);

    // Unsynced commit of r10
    step(1, 1, 4'd10, 16'd400, 4'd10, 1, 0, 0, 0);
    step(1, 0, 4'd0, 16'd0, 4'd10, 0, 1, 0, 0);
    idle(3, 0);

    // Synced: r12 waits for trigger
    step(1, 1, 4'd12, 16'd3000, 4'd12, 0, 0, 0, 1);
    step(1, 0, 4'd0, 16'd0, 4'd12, 0, 1, 0, 1);
    idle(50, 1);
    step(1, 0, 4'd0, 16'd0, 4'd12, 0, 0, 1, 1);
    idle(3, 1);

    // Write r11 exactly on the COMMIT cycle, then read shadow r11
    step(1, 0, 4'd0, 16'd0, 4'd0, 0, 1, 0, 1);
    idle(4, 1);
    step(1, 0, 4'd0, 16'd0, 4'd0, 0, 0, 1, 1);
    step(1, 1, 4'd11, 16'd500, 4'd11, 1, 0, 0, 1);
    step(1, 0, 4'd0, 16'd0, 4'd11, 1, 0, 0, 1);
    step(1, 0, 4'd0, 16'd0, 4'd11, 0, 0, 0, 1);
    idle(2, 1);

    // Sync loss commits; request during COMMIT re-arms
    step(1, 0, 4'd0, 16'd0, 4'd0, 0, 1, 0, 1);
    idle(3, 1);
    step(1, 1, 4'd3, 16'h0aa5, 4'd3, 1, 0, 0, 0);
    step(1, 0, 4'd0, 16'd0, 4'd3, 0, 1, 0, 1);
    idle(5, 1);
    step(1, 0, 4'd0, 16'd0, 4'd3, 0, 0, 1, 1);
    idle(3, 1);

    // Trigger coinciding with a fresh request must not commit
    step(1, 1, 4'd5, 16'd1234, 4'd5, 1, 0, 0, 1);
    step(1, 0, 4'd0, 16'd0, 4'd5, 0, 1, 1, 1);
    idle(4, 1);
    step(1, 0, 4'd0, 16'd0, 4'd5, 0, 0, 1, 1);
    idle(3, 1);

    // Long armed wait: timeout build commits at 16, default build never does
    step(1, 1, 4'd7, 16'd999, 4'd7, 0, 0, 0, 1);
    step(1, 0, 4'd0, 16'd0, 4'd7, 0, 1, 0, 1);
    idle(1000, 1);
    step(1, 0, 4'd0, 16'd0, 4'd7, 0, 0, 1, 1);
    idle(3, 1);

    // Reset in the middle of a commit
    step(1, 1, 4'd0, 16'h1111, 4'd0, 0, 0, 0, 0);
    step(1, 0, 4'd0, 16'd0, 4'd0, 0, 1, 0, 0);
    step(0, 0, 4'd0, 16'd0, 4'd0, 0, 0, 0, 0);
    idle(3, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)),
           16'($urandom),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 11) != 0));
    end
    idle(4, 1);
    @(negedge clk);
    @(negedge clk);
    chk("commit_queue_drained", 256'(exp_commit_q.size()), 256'd0);
    chk("exp_queue_drained", 256'(exp_q.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
